summer_arb: RTL

Round-robin arbiter and sequencer that shares one `summer` datapath among `N_REQ` requesters. Each requester presents packets of data beats with valid/ready/last. A granted requester keeps the datapath until its last beat, so consecutive beats of one packet are summed together. Results return with the originating requester id. The block sits between the requester ports and the single `summer` instance.

---
 rtl/summer_pkg.sv | 32 +++
 rtl/summer.sv | 31 +++
 rtl/summer_arb.sv | 90 +++++++++
 3 files changed

// File: rtl/summer_pkg.sv
// Shared types and the round-robin pick helper for the summer arbiter.
// Supports up to MAX_REQ requesters; callers zero-extend their masks.
package summer_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Scan downwards so the candidate closest to ptr is the last one written.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] cand,
                                         input logic [5:0] n,
                                         input logic [5:0] ptr);
        rr_pick_t   res;
        logic [5:0] idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = ptr + 6'(k);
            if (idx >= n) idx = idx - n;
            if ((6'(k) < n) && cand[idx[4:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[4:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/summer.sv
// Registered adder: each valid beat is summed with the previous accepted beat.
// The previous value persists across idle cycles and clears only on reset.
module summer #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid) begin
            prev      <= in_data;
            out_valid <= 1'b1;
            out_data  <= in_data + prev;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule

// File: rtl/summer_arb.sv
// Round-robin arbiter that shares one summer among N_REQ packet requesters.
// A winner holds the datapath until its last beat; grants are zero-bubble.
module summer_arb
    import summer_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_enable,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_first,
    output logic                    busy
);

    arb_state_t        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   sel_next;
    logic              accept;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    rr_pick_t          pick;

    always_comb pick = rr_pick(MAX_REQ'(req_valid & req_enable), 6'(N_REQ), 6'(ptr));

    // Ready is forced low while reset is held so nothing is accepted.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        sel       = owner;
        if (rst) begin
            if (state == ARB_IDLE) begin
                sel    = pick.idx[ID_W-1:0];
                accept = pick.found && (6'(pick.idx) < 6'(N_REQ));
            end else begin
                accept = req_valid[owner];
            end
            req_ready[sel] = accept;
        end
    end

    assign sel_data = req_data[sel*DATA_W +: DATA_W];
    assign sel_last = req_last[sel];
    assign sel_next = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            out_id    <= '0;
            out_first <= 1'b0;
        end else begin
            out_id    <= accept ? sel : '0;
            out_first <= accept && (state == ARB_IDLE);
            if (accept) begin
                if (sel_last) begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                    ptr   <= sel_next;
                end else begin
                    state <= ARB_LOCKED;
                    busy  <= 1'b1;
                    owner <= sel;
                end
            end
        end
    end

    summer #(.DATA_W(DATA_W)) u_summer (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_data  (sel_data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

endmodule
